// File: rtl/awb_div_sched_pkg.sv
// Shared constants, state encoding and gain clamp for the AWB gain controller
// and its sequential divider.
package awb_div_sched_pkg;

  localparam int FRAC     = 4;
  localparam int SUM_W    = 32;
  localparam int DIV_W    = SUM_W + FRAC;
  localparam int GAIN_MAX = 255;
  localparam int GAIN_MIN = 1;

  localparam logic [7:0] GAIN_UNITY = 8'(1 << FRAC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV_R  = 2'd1,
    DIV_B  = 2'd2,
    UPDATE = 2'd3
  } state_e;

  // Saturate a full-width quotient into the 8-bit gain range.
  function automatic logic [7:0] clamp_gain(input logic [DIV_W-1:0] q);
    if (q > DIV_W'(GAIN_MAX)) begin
      return 8'(GAIN_MAX);
    end else if (q < DIV_W'(GAIN_MIN)) begin
      return 8'(GAIN_MIN);
    end else begin
      return q[7:0];
    end
  endfunction

endpackage

// File: rtl/awb_div_sched_div.sv
// Restoring shift divider: one quotient bit per cycle, done pulse W+1 cycles
// after an accepted start. Starts arriving while running are ignored.
module awb_seq_div
  import awb_div_sched_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int CNT_W = $clog2(W + 1);

  logic             run_q,  run_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [W-1:0]     quot_q, quot_d;
  logic [W-1:0]     rem_q,  rem_d;
  logic [W-1:0]     dsr_q,  dsr_d;
  logic             done_q, done_d;

  logic [W:0] rem_shift;
  logic [W:0] diff;

  always_comb begin
    run_d     = run_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    done_d    = 1'b0;
    rem_shift = {rem_q, quot_q[W-1]};
    diff      = rem_shift - {1'b0, dsr_q};

    if (run_q) begin
      // Top bit of diff is the borrow: set means the divisor did not fit.
      if (!diff[W]) begin
        rem_d  = diff[W-1:0];
        quot_d = {quot_q[W-2:0], 1'b1};
      end else begin
        rem_d  = rem_shift[W-1:0];
        quot_d = {quot_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      run_d  = 1'b1;
      cnt_d  = CNT_W'(W);
      quot_d = dividend;
      rem_d  = '0;
      dsr_d  = divisor;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      done_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      done_q <= done_d;
    end
  end

  assign quotient = quot_q;
  assign done     = done_q;

endmodule

// File: rtl/awb_div_sched.sv
// AWB gain controller: computes red and blue gains (G/R, G/B) back-to-back on
// one shared sequential divider, with a one-deep shadow for overlapping frames.
module awb_div_sched
  import awb_div_sched_pkg::*;
(
  input  logic             pclk,
  input  logic             rst,
  input  logic             stat_done,
  input  logic [SUM_W-1:0] sum_r,
  input  logic [SUM_W-1:0] sum_g,
  input  logic [SUM_W-1:0] sum_b,
  input  logic             awb_en,
  input  logic [7:0]       man_r_gain,
  input  logic [7:0]       man_b_gain,
  output logic [7:0]       r_gain,
  output logic [7:0]       g_gain,
  output logic [7:0]       b_gain,
  output logic             gain_valid,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
  logic [SUM_W-1:0] sh_r_q, sh_r_d, sh_g_q, sh_g_d, sh_b_q, sh_b_d;
  logic             pend_q, pend_d;
  logic             wait_q, wait_d;
  logic [7:0]       r_res_q, r_res_d, b_res_q, b_res_d;
  logic [7:0]       r_gain_q, r_gain_d, b_gain_q, b_gain_d;
  logic             valid_q, valid_d;

  logic             div_start;
  logic [DIV_W-1:0] div_dividend;
  logic [DIV_W-1:0] div_divisor;
  logic [DIV_W-1:0] div_quot;
  logic             div_done;

  awb_seq_div #(.W(DIV_W)) u_div (
    .pclk     (pclk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quot),
    .done     (div_done)
  );

  always_comb begin
    state_d      = state_q;
    sum_r_d      = sum_r_q;
    sum_g_d      = sum_g_q;
    sum_b_d      = sum_b_q;
    sh_r_d       = sh_r_q;
    sh_g_d       = sh_g_q;
    sh_b_d       = sh_b_q;
    pend_d       = pend_q;
    wait_d       = wait_q;
    r_res_d      = r_res_q;
    b_res_d      = b_res_q;
    r_gain_d     = r_gain_q;
    b_gain_d     = b_gain_q;
    valid_d      = 1'b0;
    div_start    = 1'b0;
    div_dividend = {sum_g_q, {FRAC{1'b0}}};
    div_divisor  = (state_q == DIV_B) ? {{FRAC{1'b0}}, sum_b_q}
                                      : {{FRAC{1'b0}}, sum_r_q};

    case (state_q)
      IDLE: begin
        if (stat_done) begin
          sum_r_d = sum_r;
          sum_g_d = sum_g;
          sum_b_d = sum_b;
          wait_d  = 1'b0;
          state_d = DIV_R;
        end
      end
      DIV_R: begin
        if (sum_r_q == '0) begin
          r_res_d = 8'(GAIN_MAX);
          state_d = DIV_B;
        end else if (!wait_q) begin
          div_start = 1'b1;
          wait_d    = 1'b1;
        end else if (div_done) begin
          r_res_d = clamp_gain(div_quot);
          wait_d  = 1'b0;
          state_d = DIV_B;
        end
      end
      DIV_B: begin
        if (sum_b_q == '0) begin
          b_res_d = 8'(GAIN_MAX);
          state_d = UPDATE;
        end else if (!wait_q) begin
          div_start = 1'b1;
          wait_d    = 1'b1;
        end else if (div_done) begin
          b_res_d = clamp_gain(div_quot);
          wait_d  = 1'b0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        r_gain_d = r_res_q;
        b_gain_d = b_res_q;
        valid_d  = 1'b1;
        // A frame arriving right now is newer than anything in the shadow.
        if (pend_q || stat_done) begin
          sum_r_d = stat_done ? sum_r : sh_r_q;
          sum_g_d = stat_done ? sum_g : sh_g_q;
          sum_b_d = stat_done ? sum_b : sh_b_q;
          pend_d  = 1'b0;
          wait_d  = 1'b0;
          state_d = DIV_R;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stat_done && (state_q == DIV_R || state_q == DIV_B)) begin
      sh_r_d = sum_r;
      sh_g_d = sum_g;
      sh_b_d = sum_b;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= IDLE;
      sum_r_q  <= '0;
      sum_g_q  <= '0;
      sum_b_q  <= '0;
      sh_r_q   <= '0;
      sh_g_q   <= '0;
      sh_b_q   <= '0;
      pend_q   <= 1'b0;
      wait_q   <= 1'b0;
      r_res_q  <= GAIN_UNITY;
      b_res_q  <= GAIN_UNITY;
      r_gain_q <= GAIN_UNITY;
      b_gain_q <= GAIN_UNITY;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_r_q  <= sum_r_d;
      sum_g_q  <= sum_g_d;
      sum_b_q  <= sum_b_d;
      sh_r_q   <= sh_r_d;
      sh_g_q   <= sh_g_d;
      sh_b_q   <= sh_b_d;
      pend_q   <= pend_d;
      wait_q   <= wait_d;
      r_res_q  <= r_res_d;
      b_res_q  <= b_res_d;
      r_gain_q <= r_gain_d;
      b_gain_q <= b_gain_d;
      valid_q  <= valid_d;
    end
  end

  assign r_gain     = awb_en ? r_gain_q : man_r_gain;
  assign b_gain     = awb_en ? b_gain_q : man_b_gain;
  assign g_gain     = GAIN_UNITY;
  assign gain_valid = valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_awb_div_sched.sv
// Directed bench for awb_div_sched: vector table of sums with hand-computed
// gains and latencies, plus sequences for overlap, reset and manual mode.
module tb_awb_div_sched;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        stat_done = 1'b0;
  logic [31:0] sum_r = '0, sum_g = '0, sum_b = '0;
  logic        awb_en = 1'b1;
  logic [7:0]  man_r_gain = '0, man_b_gain = '0;
  logic [7:0]  r_gain, g_gain, b_gain;
  logic        gain_valid, busy;

  int total  = 0;
  int passed = 0;

  awb_div_sched dut (
    .pclk       (pclk),
    .rst        (rst),
    .stat_done  (stat_done),
    .sum_r      (sum_r),
    .sum_g      (sum_g),
    .sum_b      (sum_b),
    .awb_en     (awb_en),
    .man_r_gain (man_r_gain),
    .man_b_gain (man_b_gain),
    .r_gain     (r_gain),
    .g_gain     (g_gain),
    .b_gain     (b_gain),
    .gain_valid (gain_valid),
    .busy       (busy)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
    logic [7:0]  er;
    logic [7:0]  eb;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Drives a one-cycle stat_done; returns just after the edge that sampled it.
  task automatic pulse(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
    @(posedge pclk); #1;
    stat_done = 1'b1; sum_r = r; sum_g = g; sum_b = b;
    @(posedge pclk); #1;
    stat_done = 1'b0;
  endtask

  // Counts cycles until gain_valid, starting at offset start; also counts
  // cycles with busy low on the way.
  task automatic wait_valid(input int start, output int n, output int idle);
    n = start;
    idle = 0;
    while (n < 400) begin
      @(negedge pclk);
      if (gain_valid) break;
      if (!busy) idle++;
      n++;
    end
  endtask

  task automatic run_vec(input int i);
    int n, idle;
    pulse(vecs[i].r, vecs[i].g, vecs[i].b);
    wait_valid(1, n, idle);
    chk($sformatf("v%0d_latency", i), n, vecs[i].lat);
    chk($sformatf("v%0d_r_gain", i), r_gain, vecs[i].er);
    chk($sformatf("v%0d_b_gain", i), b_gain, vecs[i].eb);
    chk($sformatf("v%0d_g_gain", i), g_gain, 16);
    @(negedge pclk);
    chk($sformatf("v%0d_valid_width", i), gain_valid, 0);
    chk($sformatf("v%0d_busy_after", i), busy, 0);
    $display("vec %0d: r=%0d g=%0d b=%0d -> r_gain=%0d b_gain=%0d lat=%0d",
             i, vecs[i].r, vecs[i].g, vecs[i].b, r_gain, b_gain, n);
  endtask

  initial begin
    int n, idle, bad, cnt;

    vecs[0] = '{32'd1000,    32'd2000,    32'd4000,     8'd32,  8'd8,   78};
    vecs[1] = '{32'd1000,    32'd100000,  32'd10000000, 8'd255, 8'd1,   78};
    vecs[2] = '{32'd0,       32'd2000,    32'd2000,     8'd255, 8'd16,  41};
    vecs[3] = '{32'd3000,    32'd3000,    32'd0,        8'd16,  8'd255, 41};
    vecs[4] = '{32'd0,       32'd5,       32'd0,        8'd255, 8'd255, 4};
    vecs[5] = '{32'd3,       32'd1,       32'd7,        8'd5,   8'd2,   78};
    vecs[6] = '{32'd5,       32'd0,       32'd5,        8'd1,   8'd1,   78};
    vecs[7] = '{32'd16,      32'd256,     32'd17,       8'd255, 8'd240, 78};
    vecs[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd16, 8'd16,  78};
    vecs[9] = '{32'd16,      32'd255,     32'd4080,     8'd255, 8'd1,   78};

    repeat (3) @(posedge pclk);
    #1 rst = 1'b0;
    @(negedge pclk);
    chk("reset_r_gain", r_gain, 16);
    chk("reset_b_gain", b_gain, 16);
    chk("reset_g_gain", g_gain, 16);
    chk("reset_valid", gain_valid, 0);
    chk("reset_busy", busy, 0);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Overlapping frame at T+10: first result, then restart with no IDLE gap.
    pulse(32'd1000, 32'd2000, 32'd4000);
    repeat (8) @(posedge pclk);
    pulse(32'd500, 32'd500, 32'd500);
    wait_valid(11, n, idle);
    chk("pend_first_latency", n, 78);
    chk("pend_first_r", r_gain, 32);
    chk("pend_first_b", b_gain, 8);
    wait_valid(1, n, idle);
    chk("pend_second_gap", n, 77);
    chk("pend_no_idle", idle, 0);
    chk("pend_second_r", r_gain, 16);
    chk("pend_second_b", b_gain, 16);
    $display("pending: second result r_gain=%0d b_gain=%0d gap=%0d", r_gain, b_gain, n);
    @(negedge pclk);
    chk("pend_busy_after", busy, 0);

    // stat_done in the UPDATE cycle (T+77) must not be lost.
    pulse(32'd1000, 32'd2000, 32'd4000);
    repeat (75) @(posedge pclk);
    pulse(32'd3, 32'd1, 32'd7);
    wait_valid(78, n, idle);
    chk("upd_first_latency", n, 78);
    chk("upd_first_r", r_gain, 32);
    wait_valid(1, n, idle);
    chk("upd_second_gap", n, 77);
    chk("upd_second_r", r_gain, 5);
    chk("upd_second_b", b_gain, 2);
    $display("update-cycle frame: r_gain=%0d b_gain=%0d gap=%0d", r_gain, b_gain, n);
    @(negedge pclk);

    // Reset mid-division discards the result.
    run_vec(0);
    pulse(32'd1000, 32'd100000, 32'd10000000);
    repeat (28) @(posedge pclk);
    @(posedge pclk); #1 rst = 1'b1;
    @(posedge pclk); #1 rst = 1'b0;
    @(negedge pclk);
    chk("midrst_r_gain", r_gain, 16);
    chk("midrst_b_gain", b_gain, 16);
    chk("midrst_busy", busy, 0);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge pclk);
      if (gain_valid) cnt++;
    end
    chk("midrst_no_valid", cnt, 0);
    $display("mid-division reset: r_gain=%0d b_gain=%0d stray_valids=%0d", r_gain, b_gain, cnt);
    run_vec(5);

    // Manual mode: outputs track man_* while computation proceeds underneath.
    awb_en = 1'b0; man_r_gain = 8'd40; man_b_gain = 8'd20;
    pulse(32'd1000, 32'd2000, 32'd4000);
    n = 1; bad = 0;
    while (n < 400) begin
      @(negedge pclk);
      if (r_gain != 8'd40 || b_gain != 8'd20) bad++;
      if (gain_valid) break;
      n++;
    end
    chk("man_latency", n, 78);
    chk("man_outputs_held", bad, 0);
    chk("man_g_gain", g_gain, 16);
    @(negedge pclk);
    awb_en = 1'b1;
    #1;
    chk("auto_r_gain", r_gain, 32);
    chk("auto_b_gain", b_gain, 8);
    $display("manual->auto: r_gain=%0d b_gain=%0d held_errors=%0d", r_gain, b_gain, bad);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
